msx_ppi: RTL

MSX_PPI -- requirements
Module: msx_ppi

---
 rtl/msx_ppi_pkg.sv | 21 ++
 rtl/ppi_click_stretch.sv | 30 +++
 rtl/msx_ppi.sv | 117 +++++++++++
 3 files changed

// File: rtl/msx_ppi_pkg.sv
// Shared constants for the MSX 8255-style PPI: port indices, reset values
// and the bit layout of port C.
package msx_ppi_pkg;

   localparam logic [1:0] PPI_PA  = 2'd0;
   localparam logic [1:0] PPI_PB  = 2'd1;
   localparam logic [1:0] PPI_PC  = 2'd2;
   localparam logic [1:0] PPI_CTL = 2'd3;

   localparam logic [7:0] PPI_MODE_RST = 8'h9B;
   localparam logic [7:0] PPI_PORT_RST = 8'h00;

   // port C bit positions; the keyboard row occupies PC_ROW +: PC_ROW_W
   localparam int PC_ROW   = 0;
   localparam int PC_ROW_W = 4;
   localparam int PC_MOTOR = 4;
   localparam int PC_CASOUT = 5;
   localparam int PC_CAPS  = 6;
   localparam int PC_CLICK = 7;

endpackage

// File: rtl/ppi_click_stretch.sv
// Key-click pulse stretcher: a down-counter loaded on each click edge, with
// the output high until terminal count. CLICK_LEN=0 passes the level through.
module ppi_click_stretch #(
   parameter logic [15:0] CLICK_LEN = 16'd2000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic trig,
   input  logic clr,
   input  logic level,
   output logic click
);

   logic [15:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= 16'd0;
      end else if (clr) begin
         cnt_q <= 16'd0;
      end else if (trig) begin
         cnt_q <= CLICK_LEN;
      end else if (cnt_q != 16'd0) begin
         cnt_q <= cnt_q - 16'd1;
      end
   end

   assign click = (CLICK_LEN == 16'd0) ? level : (cnt_q != 16'd0);

endmodule

// File: rtl/msx_ppi.sv
// MSX PPI (ports A8h-ABh): slot select, keyboard scan and cassette/LED/click.
// Define MSX_PPI_BSR_EN to enable port C bit set/reset via the control port.
module msx_ppi
   import msx_ppi_pkg::*;
#(
   parameter logic [15:0] CLICK_LEN = 16'd2000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ppi_n,
   input  logic       wr_n,
   input  logic       rd_n,
   input  logic [1:0] addr,
   input  logic [7:0] d_in,
   output logic [7:0] d_out,
   output logic [7:0] slot_sel,
   input  logic [7:0] kb_col,
   output logic [3:0] kb_row,
   output logic       cas_motor_n,
   output logic       cas_out,
   output logic       caps_led_n,
   output logic       click
);

   logic       wr_act;
   logic       wr_act_q;
   logic       commit;
   logic [7:0] port_a, port_a_next;
   logic [7:0] port_c, port_c_next;
   logic [7:0] mode_q, mode_next;
   logic [7:0] kb_meta, kb_sync;
   logic       click_trig;
   logic       click_clr;

   // resetting wr_act_q high blocks a commit from a strobe already low at release
   assign wr_act = ~ppi_n & ~wr_n;
   assign commit = wr_act & ~wr_act_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_act_q <= 1'b1;
         port_a   <= PPI_PORT_RST;
         port_c   <= PPI_PORT_RST;
         mode_q   <= PPI_MODE_RST;
         kb_meta  <= 8'hFF;
         kb_sync  <= 8'hFF;
      end else begin
         wr_act_q <= wr_act;
         port_a   <= port_a_next;
         port_c   <= port_c_next;
         mode_q   <= mode_next;
         kb_meta  <= kb_col;
         kb_sync  <= kb_meta;
      end
   end

   always_comb begin
      port_a_next = port_a;
      port_c_next = port_c;
      mode_next   = mode_q;
      click_trig  = 1'b0;
      click_clr   = 1'b0;
      if (commit) begin
         case (addr)
            PPI_PA: port_a_next = d_in;
            PPI_PC: begin
               port_c_next = d_in;
               click_trig  = d_in[PC_CLICK] != port_c[PC_CLICK];
            end
            PPI_CTL: begin
               if (d_in[7]) begin
                  mode_next   = d_in;
                  port_a_next = PPI_PORT_RST;
                  port_c_next = PPI_PORT_RST;
                  click_clr   = 1'b1;
               end else begin
`ifdef MSX_PPI_BSR_EN
                  port_c_next[d_in[3:1]] = d_in[0];
                  click_trig = port_c_next[PC_CLICK] != port_c[PC_CLICK];
`endif
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      d_out = 8'hFF;
      if (~ppi_n & ~rd_n & wr_n) begin
         case (addr)
            PPI_PA:  d_out = port_a;
            PPI_PB:  d_out = kb_sync;
            PPI_PC:  d_out = port_c;
            default: d_out = mode_q;
         endcase
      end
   end

   assign slot_sel    = port_a;
   assign kb_row      = port_c[PC_ROW +: PC_ROW_W];
   assign cas_motor_n = port_c[PC_MOTOR];
   assign cas_out     = port_c[PC_CASOUT];
   assign caps_led_n  = port_c[PC_CAPS];

   ppi_click_stretch #(
      .CLICK_LEN (CLICK_LEN)
   ) u_click (
      .clk     (clk),
      .reset_n (reset_n),
      .trig    (click_trig),
      .clr     (click_clr),
      .level   (port_c[PC_CLICK]),
      .click   (click)
   );

endmodule
